mult_seq_ctrl: RTL and testbench

- Sequential controller for the 16x9 unsigned multiplier.
- Accepts one operand pair over a valid/ready handshake, then steps through the multiplier bits ROWS_PER_CYC partial-product rows per cycle, accumulating into a MDMR_WD-bit register.
- Presents the product over a valid/ready output handshake.
- Optional early termination once the remaining multiplier bits are all zero.
- Sits between the operand source (bus/FIFO) and the product consumer; replaces the full-array adder tree where area matters more than latency.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_row_sum.sv | 27 ++
 rtl/mult_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and default widths for the sequential 16x9 unsigned multiplier.
package mult_pkg;

  localparam int DEF_MD_WD   = 16;
  localparam int DEF_MR_WD   = 9;
  localparam int DEF_MDMR_WD = DEF_MD_WD + DEF_MR_WD;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_e;

  typedef logic [DEF_MD_WD-1:0]   md_t;
  typedef logic [DEF_MR_WD-1:0]   mr_t;
  typedef logic [DEF_MDMR_WD-1:0] prod_t;

endpackage

// File: rtl/mult_row_sum.sv
// Combinational sum of ROWS_PER_CYC shifted partial-product rows starting at multiplier bit cnt.
module mult_row_sum
  import mult_pkg::*;
#(
  parameter int MD_WD        = DEF_MD_WD,
  parameter int MR_WD        = DEF_MR_WD,
  parameter int MDMR_WD      = MD_WD + MR_WD,
  parameter int ROWS_PER_CYC = 1,
  parameter int CNT_W        = $clog2(MR_WD + 1)
) (
  input  logic [CNT_W-1:0]   cnt,
  input  logic [MD_WD-1:0]   a_q,
  input  logic [MR_WD-1:0]   b_q,
  output logic [MDMR_WD-1:0] row_sum
);

  // Rows beyond the top multiplier bit select nothing, so no explicit range guard is needed.
  always_comb begin
    row_sum = '0;
    for (int k = 0; k < ROWS_PER_CYC; k++) begin
      if (|(b_q & (MR_WD'(1) << (int'(cnt) + k)))) begin
        row_sum = row_sum + (MDMR_WD'(a_q) << (int'(cnt) + k));
      end
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller with valid/ready operand and product handshakes.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int MD_WD        = DEF_MD_WD,
  parameter int MR_WD        = DEF_MR_WD,
  parameter int MDMR_WD      = MD_WD + MR_WD,
  parameter int ROWS_PER_CYC = 1,
  parameter int EARLY_TERM   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MD_WD-1:0]   in_a,
  input  logic [MR_WD-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MDMR_WD-1:0] out_p,
  output logic               busy
);

  localparam int CNT_W = $clog2(MR_WD + 1);

  generate
    if (ROWS_PER_CYC < 1 || (MR_WD % ROWS_PER_CYC) != 0) begin : g_bad_rows
      $error("mult_seq_ctrl: ROWS_PER_CYC must divide MR_WD");
    end
  endgenerate

  mult_state_e        state, state_nxt;
  logic [MD_WD-1:0]   a_q;
  logic [MR_WD-1:0]   b_q;
  logic [MDMR_WD-1:0] acc;
  logic [MDMR_WD-1:0] row_sum;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_rows;
  logic               rest_zero;
  logic               calc_done;

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_p     = acc;
  assign accept    = in_valid & in_ready;

  mult_row_sum #(
    .MD_WD        (MD_WD),
    .MR_WD        (MR_WD),
    .MDMR_WD      (MDMR_WD),
    .ROWS_PER_CYC (ROWS_PER_CYC),
    .CNT_W        (CNT_W)
  ) u_row_sum (
    .cnt     (cnt),
    .a_q     (a_q),
    .b_q     (b_q),
    .row_sum (row_sum)
  );

  // Finish on the last row group, or early once no set multiplier bits remain above this group.
  always_comb begin
    last_rows = (int'(cnt) + ROWS_PER_CYC == MR_WD);
    rest_zero = ((b_q >> (int'(cnt) + ROWS_PER_CYC)) == '0);
    calc_done = last_rows || ((EARLY_TERM != 0) && rest_zero);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture and accumulate stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= acc + row_sum;
      cnt <= cnt + CNT_W'(ROWS_PER_CYC);
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: six builds covering every ROWS_PER_CYC / EARLY_TERM combination.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  localparam int ND  = 6;
  localparam int NTX = 1700;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid  [ND];
  logic  in_ready  [ND];
  md_t   in_a      [ND];
  mr_t   in_b      [ND];
  logic  out_valid [ND];
  logic  out_ready [ND];
  prod_t out_p     [ND];
  logic  busy      [ND];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  prod_t exp_p [ND][NTX];
  int    exp_l [ND][NTX];
  int    t_acc [ND][NTX];
  int    wr_i  [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Builds 0..2: early termination with 1/3/9 rows; builds 3..5: fixed latency with 1/3/9 rows
  for (genvar g = 0; g < ND; g++) begin : g_dut
    mult_seq_ctrl #(
      .MD_WD        (16),
      .MR_WD        (9),
      .MDMR_WD      (25),
      .ROWS_PER_CYC ((g % 3 == 0) ? 1 : ((g % 3 == 1) ? 3 : 9)),
      .EARLY_TERM   ((g < 3) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_p     (out_p[g]),
      .busy      (busy[g])
    );
  end

  function automatic int rows_of(int d);
    return (d % 3 == 0) ? 1 : ((d % 3 == 1) ? 3 : 9);
  endfunction

  // Reference latency: multiplier bits consumed in groups, stopping once nothing is left above.
  function automatic int exp_lat(int d, mr_t b);
    int r   = rows_of(d);
    int msb = -1;
    if (d >= 3) return 9 / r;
    for (int i = 0; i < 9; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + r) / r;
  endfunction

  task automatic run_op(input int d, input md_t a, input mr_t b,
                        output int lat, output prod_t prod, output int bsy);
    @(negedge clk);
    in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b;
    @(negedge clk);
    in_valid[d] = 1'b0; in_a[d] = md_t'($urandom); in_b[d] = mr_t'($urandom);
    lat = 0; bsy = 0; prod = '0;
    while (!out_valid[d] && lat < 30) begin
      if (busy[d]) bsy++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid[d]) begin
      lat = -1;
      return;
    end
    prod = out_p[d];
    for (int i = 0; i < 30 && busy[d]; i++) begin
      bsy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      vectors += 4;
      if (in_ready[d] !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready d%0d: got %b want 0", d, in_ready[d]); end
      if (out_valid[d] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid d%0d: got %b want 0", d, out_valid[d]); end
      if (busy[d] !== 1'b0) begin miscompares++; $display("FAIL reset_busy d%0d: got %b want 0", d, busy[d]); end
      if (out_p[d] !== '0) begin miscompares++; $display("FAIL reset_out_p d%0d: got %h want 0", d, out_p[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (in_ready[d] !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready d%0d: got %b want 1", d, in_ready[d]); end
    end
  endtask

  task automatic test_basic();
    int lat, bsy; prod_t p;
    run_op(0, 16'h1234, 9'h005, lat, p, bsy);
    vectors += 3;
    if (lat !== 3) begin miscompares++; $display("FAIL basic_latency: got %0d want 3", lat); end
    if (p !== 25'h0005B04) begin miscompares++; $display("FAIL basic_product: got %h want 0005b04", p); end
    if (bsy !== 4) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 4", bsy); end
  endtask

  task automatic test_max();
    int lat, bsy; prod_t p;
    int want_l [4] = '{9, 3, 1, 9};
    for (int d = 0; d < 4; d++) begin
      run_op(d, 16'hFFFF, 9'h1FF, lat, p, bsy);
      vectors += 2;
      if (lat !== want_l[d]) begin miscompares++; $display("FAIL max_latency d%0d: got %0d want %0d", d, lat, want_l[d]); end
      if (p !== 25'h1FEFE01) begin miscompares++; $display("FAIL max_product d%0d: got %h want 1fefe01", d, p); end
    end
  endtask

  task automatic test_zero();
    int lat, bsy; prod_t p;
    int dl [3] = '{0, 3, 5};
    int wl [3] = '{1, 9, 1};
    for (int i = 0; i < 3; i++) begin
      run_op(dl[i], 16'hABCD, 9'h000, lat, p, bsy);
      vectors += 2;
      if (lat !== wl[i]) begin miscompares++; $display("FAIL zero_latency d%0d: got %0d want %0d", dl[i], lat, wl[i]); end
      if (p !== '0) begin miscompares++; $display("FAIL zero_product d%0d: got %h want 0", dl[i], p); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_a[0] = 16'h0001; in_b[0] = 9'h001;
    vectors++;
    if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL bp_initial_ready: got %b want 1", in_ready[0]); end
    @(negedge clk);
    in_a[0] = 16'h0007; in_b[0] = 9'h003;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors += 3;
      if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid cyc%0d: got %b want 1", i, out_valid[0]); end
      if (out_p[0] !== 25'd1) begin miscompares++; $display("FAIL bp_out_p cyc%0d: got %h want 1", i, out_p[0]); end
      if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL bp_idle_ready: got %b want 1", in_ready[0]); end
    if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL bp_idle_valid: got %b want 0", out_valid[0]); end
    @(negedge clk);
    in_valid[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL bp_second_accept: got busy %b want 1", busy[0]); end
    lat = 0;
    while (!out_valid[0] && lat < 30) begin @(negedge clk); lat++; end
    vectors += 2;
    if (lat !== 2) begin miscompares++; $display("FAIL bp_second_latency: got %0d want 2", lat); end
    if (out_p[0] !== 25'd21) begin miscompares++; $display("FAIL bp_second_product: got %h want 15", out_p[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bsy; prod_t p;
    @(negedge clk);
    in_valid[0] = 1'b1; in_a[0] = 16'hFFFF; in_b[0] = 9'h1FF;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before_reset: got %b want 1", busy[0]); end
    rst = 1'b1;
    #1;
    vectors += 4;
    if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy[0]); end
    if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", out_valid[0]); end
    if (out_p[0] !== '0) begin miscompares++; $display("FAIL mid_out_p: got %h want 0", out_p[0]); end
    if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL mid_in_ready: got %b want 0", in_ready[0]); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: got %b want 1", in_ready[0]); end
    run_op(0, 16'h0003, 9'h100, lat, p, bsy);
    vectors += 2;
    if (lat !== 9) begin miscompares++; $display("FAIL mid_after_latency: got %0d want 9", lat); end
    if (p !== 25'h0000300) begin miscompares++; $display("FAIL mid_after_product: got %h want 0000300", p); end
  endtask

  task automatic test_back_to_back();
    int t [4];
    int n = 0;
    @(negedge clk);
    in_valid[1] = 1'b1; in_a[1] = 16'hFFFF; in_b[1] = 9'h1FF;
    for (int i = 0; i < 20; i++) begin
      if (in_ready[1] && n < 4) begin t[n] = cyc; n++; end
      if (out_valid[1]) begin
        vectors++;
        if (out_p[1] !== 25'h1FEFE01) begin miscompares++; $display("FAIL b2b_product: got %h want 1fefe01", out_p[1]); end
      end
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    vectors++;
    if (n !== 4) begin
      miscompares++; $display("FAIL b2b_accepts: got %0d want 4", n);
    end else begin
      for (int k = 1; k < 4; k++) begin
        vectors++;
        if (t[k] - t[k-1] !== 5) begin miscompares++; $display("FAIL b2b_spacing %0d: got %0d want 5", k, t[k] - t[k-1]); end
      end
    end
    for (int i = 0; i < 30 && busy[1]; i++) @(negedge clk);
  endtask

  task automatic drive_rand(input int dd);
    md_t a; mr_t b; int gap, w;
    for (int n = 0; n < NTX; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid[dd] = 1'b0; in_a[dd] = md_t'($urandom); in_b[dd] = mr_t'($urandom);
        @(negedge clk);
      end
      a = md_t'($urandom);
      b = mr_t'($urandom);
      case ($urandom_range(0, 7))
        0, 1: b = mr_t'($urandom_range(0, 7));
        2:    begin a = 16'hFFFF; b = 9'h1FF; end
        3:    b = '0;
        default: ;
      endcase
      in_valid[dd] = 1'b1; in_a[dd] = a; in_b[dd] = b;
      w = 0;
      while (!in_ready[dd] && w < 40) begin @(negedge clk); w++; end
      if (!in_ready[dd]) begin
        vectors++; miscompares++;
        $display("FAIL rand_accept_timeout d%0d txn %0d", dd, n);
        break;
      end
      exp_p[dd][n] = prod_t'(a) * prod_t'(b);
      exp_l[dd][n] = exp_lat(dd, b);
      wr_i[dd] = n + 1;
      @(negedge clk);
      t_acc[dd][n] = cyc;
    end
    in_valid[dd] = 1'b0;
  endtask

  task automatic mon_rand(input int dd);
    int got = 0, idle = 0, rd = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    prod_t prev_p = '0;
    while (got < NTX && idle < 200) begin
      @(negedge clk);
      if (prev_v && !prev_r) begin
        vectors++;
        if (out_valid[dd] !== 1'b1 || out_p[dd] !== prev_p) begin
          miscompares++;
          $display("FAIL rand_hold d%0d: got v=%b p=%h want v=1 p=%h", dd, out_valid[dd], out_p[dd], prev_p);
        end
      end
      out_ready[dd] = ($urandom_range(0, 3) != 0);
      if (out_valid[dd]) begin
        idle = 0;
        if (rd >= wr_i[dd]) begin
          vectors++; miscompares++;
          $display("FAIL rand_extra_product d%0d: got %h with none outstanding", dd, out_p[dd]);
        end else begin
          if (!prev_v) begin
            vectors++;
            if (cyc - t_acc[dd][rd] !== exp_l[dd][rd]) begin
              miscompares++;
              $display("FAIL rand_latency d%0d txn %0d: got %0d want %0d", dd, rd, cyc - t_acc[dd][rd], exp_l[dd][rd]);
            end
          end
          if (out_ready[dd]) begin
            vectors++;
            if (out_p[dd] !== exp_p[dd][rd]) begin
              miscompares++;
              $display("FAIL rand_product d%0d txn %0d: got %h want %h", dd, rd, out_p[dd], exp_p[dd][rd]);
            end
            rd++; got++;
          end
        end
      end else begin
        idle++;
      end
      prev_v = out_valid[dd]; prev_r = out_ready[dd]; prev_p = out_p[dd];
    end
    vectors++;
    if (got !== NTX) begin miscompares++; $display("FAIL rand_count d%0d: got %0d want %0d", dd, got, NTX); end
  endtask

  task automatic test_random();
    for (int d = 0; d < ND; d++) wr_i[d] = 0;
    for (int d = 0; d < ND; d++) begin
      automatic int dd = d;
      fork
        drive_rand(dd);
        mon_rand(dd);
      join_none
    end
    wait fork;
    @(negedge clk);
    for (int d = 0; d < ND; d++) out_ready[d] = 1'b1;
    for (int d = 0; d < ND; d++) begin
      automatic int extra = 0;
      for (int i = 0; i < 20; i++) begin
        if (d == 0) @(negedge clk);
        if (out_valid[d]) extra++;
      end
      vectors++;
      if (extra !== 0) begin miscompares++; $display("FAIL rand_trailing_output d%0d: got %0d cycles valid want 0", d, extra); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; out_ready[d] = 1'b1;
    end
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
